// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared decode payload type and sizing for the warp instruction buffer
package VX_gpu_pkg;

    localparam int NUM_WARPS = 4;
    localparam int NW_BITS   = $clog2(NUM_WARPS);

    typedef enum logic [1:0] {
        EX_ALU = 2'd0,
        EX_LSU = 2'd1,
        EX_FPU = 2'd2,
        EX_SFU = 2'd3
    } ex_type_t;

    typedef struct packed {
        logic [7:0] uuid;
        logic       wb;
        ex_type_t   ex_type;
        logic [3:0] op_type;
        logic       use_imm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } data_t;

    localparam int DATA_W = $bits(data_t);

    function automatic logic [NW_BITS-1:0] wid_of(input int w);
        return NW_BITS'(w);
    endfunction

endpackage

// File: rtl/vx_ibuf_queue.sv
// rtl/vx_ibuf_queue.sv - single-warp in-order FIFO; storage is not reset, only pointers and count
module vx_ibuf_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// rtl/vx_warp_ibuffer.sv - per-warp instruction buffer between decode and issue
module vx_warp_ibuffer
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS = VX_gpu_pkg::NUM_WARPS,
    parameter int DEPTH     = 2,
    parameter int DATA_W    = VX_gpu_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_valid,
    input  logic [$clog2(NUM_WARPS)-1:0]   dec_wid,
    input  logic [DATA_W-1:0]              dec_data,
    output logic                           dec_ready,
    output logic [NUM_WARPS-1:0]           ibuf_valid,
    output logic [NUM_WARPS*DATA_W-1:0]    ibuf_data,
    input  logic [NUM_WARPS-1:0]           ibuf_ready,
    output logic [NUM_WARPS-1:0]           pop_mask,
    output logic [NUM_WARPS-1:0]           empty_mask
);

    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_WARPS-1:0] full_vec;
    logic [NUM_WARPS-1:0] push_vec;
    logic [NUM_WARPS-1:0] fire;
    logic [CNT_W-1:0]     count [NUM_WARPS];

    // dec_ready looks only at registered fullness, so a same-cycle pop never opens a slot
    assign dec_ready  = !full_vec[dec_wid];
    assign ibuf_valid = ~empty_mask;
    assign fire       = ibuf_valid & ibuf_ready;

    always_comb begin
        push_vec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (dec_valid && dec_ready && (dec_wid == WID_W'(w))) begin
                push_vec[w] = 1'b1;
            end
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
        vx_ibuf_queue #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_queue (
            .clk      (clk),
            .reset    (reset),
            .push     (push_vec[w]),
            .pop      (fire[w]),
            .data_in  (dec_data),
            .data_out (ibuf_data[w*DATA_W +: DATA_W]),
            .count    (count[w]),
            .full     (full_vec[w]),
            .empty    (empty_mask[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_mask <= '0;
        end else begin
            pop_mask <= fire;
        end
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// tb/tb_vx_warp_ibuffer.sv - directed self-checking bench for vx_warp_ibuffer
module tb_vx_warp_ibuffer;
    import VX_gpu_pkg::*;

    localparam int NW = 4;
    localparam int DW = VX_gpu_pkg::DATA_W;

    logic           clk;
    logic           reset;
    logic           dec_valid;
    logic [1:0]     dec_wid;
    logic [DW-1:0]  dec_data;
    logic           dec_ready;
    logic [NW-1:0]  ibuf_valid;
    logic [NW*DW-1:0] ibuf_data;
    logic [NW-1:0]  ibuf_ready;
    logic [NW-1:0]  pop_mask;
    logic [NW-1:0]  empty_mask;

    int checks = 0;
    int errors = 0;

    vx_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(2), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_wid    (dec_wid),
        .dec_data   (dec_data),
        .dec_ready  (dec_ready),
        .ibuf_valid (ibuf_valid),
        .ibuf_data  (ibuf_data),
        .ibuf_ready (ibuf_ready),
        .pop_mask   (pop_mask),
        .empty_mask (empty_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] head(input int w);
        logic [DW-1:0] d;
        d = ibuf_data[w*DW +: DW];
        return 64'(d);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int w, input logic [DW-1:0] d);
        dec_valid = 1'b1;
        dec_wid   = 2'(w);
        dec_data  = d;
        tick();
        dec_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        dec_valid  = 1'b0;
        dec_wid    = '0;
        dec_data   = '0;
        ibuf_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(ibuf_valid), 64'h0);
        check("rst_empty", 64'(empty_mask), 64'hF);
        check("rst_ready", 64'(dec_ready), 64'h1);
        check("rst_popm", 64'(pop_mask), 64'h0);

        // single push to warp 2
        push(2, DW'(36'hA5));
        check("w2_valid", 64'(ibuf_valid), 64'h4);
        check("w2_data", head(2), 64'hA5);
        check("w2_empty", 64'(empty_mask), 64'hB);
        ibuf_ready = 4'b0100;
        tick();
        ibuf_ready = 4'b0000;
        check("w2_popm", 64'(pop_mask), 64'h4);
        check("w2_drained", 64'(ibuf_valid), 64'h0);
        tick();
        check("w2_popm_clr", 64'(pop_mask), 64'h0);

        // overfill warp 0
        push(0, DW'(1));
        push(0, DW'(2));
        dec_valid = 1'b1;
        dec_wid   = 2'd0;
        dec_data  = DW'(3);
        check("w0_full_ready", 64'(dec_ready), 64'h0);
        tick();
        dec_valid = 1'b0;
        check("w0_head1", head(0), 64'h1);
        ibuf_ready = 4'b0001;
        tick();
        check("w0_head2", head(0), 64'h2);
        check("w0_popm", 64'(pop_mask), 64'h1);
        tick();
        ibuf_ready = 4'b0000;
        check("w0_empty", 64'(ibuf_valid), 64'h0);
        check("w0_popm2", 64'(pop_mask), 64'h1);

        // full warp 1: pop and refused push in the same cycle
        push(1, DW'(8'h11));
        push(1, DW'(8'h12));
        dec_valid  = 1'b1;
        dec_wid    = 2'd1;
        dec_data   = DW'(8'h13);
        ibuf_ready = 4'b0010;
        #1;
        check("w1_ready_full", 64'(dec_ready), 64'h0);
        tick();
        dec_valid  = 1'b0;
        ibuf_ready = 4'b0000;
        check("w1_popm", 64'(pop_mask), 64'h2);
        check("w1_head", head(1), 64'h12);
        check("w1_valid", 64'(ibuf_valid), 64'h2);
        check("w1_ready_cnt1", 64'(dec_ready), 64'h1);
        ibuf_ready = 4'b0010;
        tick();
        ibuf_ready = 4'b0000;
        check("w1_drained", 64'(ibuf_valid), 64'h0);

        // one entry per warp, all pop together
        for (int w = 0; w < NW; w++) push(w, DW'(8'h20 + w));
        check("all_valid", 64'(ibuf_valid), 64'hF);
        check("all_head3", head(3), 64'h23);
        ibuf_ready = 4'b1111;
        tick();
        ibuf_ready = 4'b0000;
        check("all_popm", 64'(pop_mask), 64'hF);
        check("all_valid0", 64'(ibuf_valid), 64'h0);
        check("all_empty", 64'(empty_mask), 64'hF);

        // warp 3 streaming push+pop across pointer wrap
        push(3, DW'(8'h30));
        for (int i = 0; i < 5; i++) begin
            check("w3_head_pre", head(3), 64'(8'h30 + i));
            dec_valid  = 1'b1;
            dec_wid    = 2'd3;
            dec_data   = DW'(8'h31 + i);
            ibuf_ready = 4'b1000;
            tick();
            check("w3_popm", 64'(pop_mask), 64'h8);
            check("w3_ready", 64'(dec_ready), 64'h1);
        end
        dec_valid  = 1'b0;
        ibuf_ready = 4'b0000;
        check("w3_head_end", head(3), 64'h35);
        check("w3_valid_end", 64'(ibuf_valid), 64'h8);
        ibuf_ready = 4'b1000;
        tick();
        ibuf_ready = 4'b0000;
        check("w3_drained", 64'(ibuf_valid), 64'h0);

        // reset discards queued entries
        push(0, DW'(8'h40));
        push(0, DW'(8'h41));
        push(2, DW'(8'h42));
        push(2, DW'(8'h43));
        check("pre_rst_valid", 64'(ibuf_valid), 64'h5);
        dec_wid = 2'd0;
        #1;
        check("pre_rst_ready", 64'(dec_ready), 64'h0);
        reset      = 1'b1;
        ibuf_ready = 4'b1111;
        tick();
        reset      = 1'b0;
        ibuf_ready = 4'b0000;
        #1;
        check("post_rst_valid", 64'(ibuf_valid), 64'h0);
        check("post_rst_ready", 64'(dec_ready), 64'h1);
        check("post_rst_popm", 64'(pop_mask), 64'h0);
        check("post_rst_empty", 64'(empty_mask), 64'hF);
        tick();
        check("post_rst_popm2", 64'(pop_mask), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
